tow_field: RTL and testbench
============================

# tow_field

Playfield stage of the tug-of-war game, directly downstream of the player-input delegator. Each cycle it consumes the delegator's 3-bit move command and moves a single lit LED along a WIDTH-long bar. It feeds the deviate1/deviate2 position flags back to the delegator. It also detects a win, keeps saturating per-player scores, and issues a one-cycle round_reset that restarts both itself and the delegator.

## Interface
- WIDTH, 9: LED count; odd, ≥3. CENTER = WIDTH/2 (integer division).
- SCORE_W, 3: score counter width.
- PAUSE_CYCLES, 4: cycles spent in WON before restart; ≥1.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd  in  3  move command from delegator, sampled every cycle
- leds  out  WIDTH  one-hot light position; index 0 = player1 (right) end
- deviate1  out  1  light is one step toward player1 (pos == CENTER-1)
- deviate2  out  1  light is one step toward player2 (pos == CENTER+1)
- win1  out  1  high throughout a round won by player1
- win2  out  1  high throughout a round won by player2
- score1  out  SCORE_W  player1 rounds won, saturating
- score2  out  SCORE_W  player2 rounds won, saturating
- round_reset  out  1  one-cycle pulse; system ORs it into the delegator reset

## Operation
- Registers: pos (0..WIDTH-1), state, pause counter, score1, score2.
- Command codes:
  - 001 = R: pos−1.
  - 111 = L: pos+1.
  - 000 = toward-center from player1 side: pos+1 only if pos < CENTER, else hold.
  - 110 = toward-center from player2 side: pos−1 only if pos > CENTER, else hold.
  - 100 = hold.
  - 010/011/101 are illegal and treated as hold.
- States: PLAY, WON, RESTART.
- PLAY:
  - Commands applied as above.
  - R at pos 0: win1←1, score1 +1 (hold at 2^SCORE_W−1), pos unchanged, go to WON, pause counter←0.
  - L at pos WIDTH-1: same for player2.
- WON:
  - cmd ignored; win flag held; leds show the end LED.
  - Counter increments each cycle.
  - When counter == PAUSE_CYCLES−1, go to RESTART.
- RESTART (one cycle):
  - round_reset=1, pos←CENTER, win1/win2←0, cmd ignored; next state PLAY.
- deviate1/deviate2 are decoded combinationally from pos, gated to 0 outside PLAY.
- leds = one-hot(pos) in all states.
- Reset (overrides everything, any state):
  - pos=CENTER, state=PLAY, counter=0.
  - score1=score2=0, win1=win2=0, round_reset=0.
  - leds=one-hot(CENTER), deviate1=deviate2=0.

## Timing
- cmd sampled at posedge.
- pos, leds and deviate flags reflect it one cycle later (latency 1).
- Winning command at edge N:
  - win flag and score update visible after edge N.
  - WON occupies PAUSE_CYCLES cycles.
  - round_reset is high for exactly one cycle, after edge N+PAUSE_CYCLES.
  - PLAY and pos=CENTER are visible the cycle after that pulse.
- The delegator is reset by round_reset at the same edge pos returns to CENTER, so both are in center/CENTER simultaneously.
- Only one of win1/win2 can be high; there are no simultaneous wins.
- Scores are never cleared by round_reset, only by reset.
- reset during WON or RESTART aborts the round; the score increment already taken is discarded by the reset clear.

## Structure
- Package tow_pkg holds:
  - command code localparams (CMD_R=001, CMD_L=111, CMD_C1=000, CMD_C2=110, CMD_HOLD=100), shared with the delegator;
  - field state enum {PLAY, WON, RESTART}.
- Sub-module: none. The one-hot decode and saturating increment are inline.

## Test plan
- Reset, then cmd=100 for 3 cycles → leds=9'b000010000, deviate1=deviate2=0, scores 0.
- From center: cmd 001 once → pos 3, deviate1=1. Then 000 once → pos 4, deviate1=0. Then 110 at pos 4 → hold at pos 4.
- Five consecutive 001 from center:
  - After the 4th, pos 0 (leds=9'b000000001).
  - The 5th sets win1=1, score1=1.
  - win1 stays high PAUSE_CYCLES=4 cycles, then round_reset pulses once.
  - Next cycle: leds=9'b000010000, win1=0.
- Eight player2 wins with SCORE_W=3 → score2 saturates at 7 and stays 7; score1 stays 0.
- During WON, drive 001/111 every cycle → pos and timing unchanged, round_reset still after exactly 4 cycles.
- Assert reset in the second WON cycle → next cycle pos=CENTER, win2=0, scores 0, no round_reset pulse.
- Illegal cmd 010, 011, 101 at pos 2 → pos stays 2.

Source files
------------

// File: rtl/tow_field_pkg.sv
// Shared definitions for the tug-of-war playfield and its input delegator.
// Command codes are common to both blocks; the state enum belongs to the field.
package tow_pkg;

    localparam int CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_R    = 3'b001;
    localparam logic [CMD_W-1:0] CMD_L    = 3'b111;
    localparam logic [CMD_W-1:0] CMD_C1   = 3'b000;
    localparam logic [CMD_W-1:0] CMD_C2   = 3'b110;
    localparam logic [CMD_W-1:0] CMD_HOLD = 3'b100;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        WON     = 2'd1,
        RESTART = 2'd2
    } field_state_t;

endpackage

// File: rtl/tow_field_if.sv
// Bundle between the delegator and the playfield: move command in, bar/score/flags out.
// master = the field that drives the bar; slave = the delegator/observer side.
interface tow_field_if
    import tow_pkg::*;
#(
    parameter int WIDTH   = 9,
    parameter int SCORE_W = 3
);
    logic [CMD_W-1:0]   cmd;
    logic [WIDTH-1:0]   leds;
    logic               deviate1;
    logic               deviate2;
    logic               win1;
    logic               win2;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               round_reset;

    modport master (
        input  cmd,
        output leds, deviate1, deviate2, win1, win2, score1, score2, round_reset
    );

    modport slave (
        output cmd,
        input  leds, deviate1, deviate2, win1, win2, score1, score2, round_reset
    );
endinterface

// File: rtl/tow_field.sv
// Tug-of-war playfield: moves a one-hot light per command, detects wins, keeps saturating scores.
// Latency 1 from cmd to leds/flags; no backpressure, cmd is consumed every cycle.
module tow_field
    import tow_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int SCORE_W      = 3,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    tow_field_if.master bus
);
    localparam int POS_W  = $clog2(WIDTH);
    localparam int CENTER = WIDTH / 2;
    localparam int CNT_W  = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [POS_W-1:0]   POS_CENTER = POS_W'(CENTER);
    localparam logic [POS_W-1:0]   POS_DEV1   = POS_W'(CENTER - 1);
    localparam logic [POS_W-1:0]   POS_DEV2   = POS_W'(CENTER + 1);
    localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(WIDTH - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [WIDTH-1:0]   LED_ONE    = WIDTH'(1);

    field_state_t       r_state;
    logic [POS_W-1:0]   r_pos;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_score1;
    logic [SCORE_W-1:0] r_score2;
    logic               r_win1;
    logic               r_win2;
    logic               r_round_reset;

    logic [WIDTH-1:0]   w_leds;
    logic               w_in_play;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= PLAY;
            r_pos         <= POS_CENTER;
            r_cnt         <= '0;
            r_score1      <= '0;
            r_score2      <= '0;
            r_win1        <= 1'b0;
            r_win2        <= 1'b0;
            r_round_reset <= 1'b0;
        end else begin
            r_round_reset <= 1'b0;
            case (r_state)
                PLAY: begin
                    case (bus.cmd)
                        CMD_R: begin
                            if (r_pos == '0) begin
                                r_win1  <= 1'b1;
                                r_cnt   <= '0;
                                r_state <= WON;
                                if (r_score1 != SCORE_MAX)
                                    r_score1 <= r_score1 + 1'b1;
                            end else begin
                                r_pos <= r_pos - 1'b1;
                            end
                        end
                        CMD_L: begin
                            if (r_pos == POS_MAX) begin
                                r_win2  <= 1'b1;
                                r_cnt   <= '0;
                                r_state <= WON;
                                if (r_score2 != SCORE_MAX)
                                    r_score2 <= r_score2 + 1'b1;
                            end else begin
                                r_pos <= r_pos + 1'b1;
                            end
                        end
                        CMD_C1: if (r_pos < POS_CENTER) r_pos <= r_pos + 1'b1;
                        CMD_C2: if (r_pos > POS_CENTER) r_pos <= r_pos - 1'b1;
                        default: ;  // hold and the illegal codes
                    endcase
                end
                WON: begin
                    // round_reset is registered so it lines up with the RESTART cycle
                    if (r_cnt == CNT_LAST) begin
                        r_state       <= RESTART;
                        r_round_reset <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESTART: begin
                    r_pos   <= POS_CENTER;
                    r_win1  <= 1'b0;
                    r_win2  <= 1'b0;
                    r_state <= PLAY;
                end
                default: r_state <= PLAY;
            endcase
        end
    end

    assign w_leds    = LED_ONE << r_pos;
    assign w_in_play = (r_state == PLAY);

    assign bus.leds        = w_leds;
    assign bus.deviate1    = w_in_play && (r_pos == POS_DEV1);
    assign bus.deviate2    = w_in_play && (r_pos == POS_DEV2);
    assign bus.win1        = r_win1;
    assign bus.win2        = r_win2;
    assign bus.score1      = r_score1;
    assign bus.score2      = r_score2;
    assign bus.round_reset = r_round_reset;

endmodule

// File: tb/tb_tow_field.sv
// Directed bench for tow_field with hand-computed expectations (WIDTH=9, SCORE_W=3, PAUSE_CYCLES=4).
module tb_tow_field;
    import tow_pkg::*;

    localparam logic [8:0] LED_C  = 9'b000010000;
    localparam logic [8:0] LED_P1 = 9'b000000001;
    localparam logic [8:0] LED_P2 = 9'b100000000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    tow_field_if #(.WIDTH(9), .SCORE_W(3)) bus ();

    tow_field #(.WIDTH(9), .SCORE_W(3), .PAUSE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic [2:0] c);
        bus.cmd = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(CMD_HOLD);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(CMD_HOLD);
        tick(CMD_HOLD);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick(CMD_HOLD);
        checks++; if (bus.leds !== LED_C) begin errors++; $display("FAIL reset_leds got=%b exp=%b", bus.leds, LED_C); end
        checks++; if ({bus.deviate1, bus.deviate2} !== 2'b00) begin errors++; $display("FAIL reset_dev got=%b exp=00", {bus.deviate1, bus.deviate2}); end
        checks++; if ({bus.score1, bus.score2} !== 6'd0) begin errors++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", bus.score1, bus.score2); end
        checks++; if ({bus.win1, bus.win2, bus.round_reset} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {bus.win1, bus.win2, bus.round_reset}); end
    endtask

    task automatic test_moves();
        tick(CMD_R);
        checks++; if (bus.leds !== 9'b000001000 || bus.deviate1 !== 1'b1) begin errors++; $display("FAIL move_r leds=%b dev1=%b exp leds=000001000 dev1=1", bus.leds, bus.deviate1); end
        tick(CMD_C1);
        checks++; if (bus.leds !== LED_C || bus.deviate1 !== 1'b0) begin errors++; $display("FAIL move_c1 leds=%b dev1=%b exp leds=%b dev1=0", bus.leds, bus.deviate1, LED_C); end
        tick(CMD_C2);
        checks++; if (bus.leds !== LED_C) begin errors++; $display("FAIL c2_at_center got=%b exp=%b", bus.leds, LED_C); end
        tick(CMD_L);
        checks++; if (bus.leds !== 9'b000100000 || bus.deviate2 !== 1'b1) begin errors++; $display("FAIL move_l leds=%b dev2=%b exp leds=000100000 dev2=1", bus.leds, bus.deviate2); end
        tick(CMD_C2);
        checks++; if (bus.leds !== LED_C || bus.deviate2 !== 1'b0) begin errors++; $display("FAIL move_c2 leds=%b dev2=%b exp leds=%b dev2=0", bus.leds, bus.deviate2, LED_C); end
        tick(CMD_C1);
        checks++; if (bus.leds !== LED_C) begin errors++; $display("FAIL c1_at_center got=%b exp=%b", bus.leds, LED_C); end
    endtask

    task automatic test_win1();
        for (int i = 0; i < 4; i++) tick(CMD_R);
        checks++; if (bus.leds !== LED_P1 || bus.win1 !== 1'b0) begin errors++; $display("FAIL win1_edge leds=%b win1=%b exp leds=%b win1=0", bus.leds, bus.win1, LED_P1); end
        tick(CMD_R);
        checks++; if (bus.win1 !== 1'b1 || bus.score1 !== 3'd1 || bus.leds !== LED_P1) begin errors++; $display("FAIL win1_set win1=%b score1=%0d leds=%b exp 1/1/%b", bus.win1, bus.score1, bus.leds, LED_P1); end
        checks++; if (bus.round_reset !== 1'b0 || bus.deviate1 !== 1'b0) begin errors++; $display("FAIL win1_first_won rr=%b dev1=%b exp 0/0", bus.round_reset, bus.deviate1); end
        for (int i = 0; i < 3; i++) begin
            tick(CMD_HOLD);
            checks++; if (bus.win1 !== 1'b1 || bus.round_reset !== 1'b0 || bus.leds !== LED_P1) begin errors++; $display("FAIL win1_won%0d win1=%b rr=%b leds=%b exp 1/0/%b", i, bus.win1, bus.round_reset, bus.leds, LED_P1); end
        end
        tick(CMD_HOLD);
        checks++; if (bus.round_reset !== 1'b1) begin errors++; $display("FAIL win1_rr got=%b exp=1", bus.round_reset); end
        tick(CMD_HOLD);
        checks++; if (bus.leds !== LED_C || bus.win1 !== 1'b0 || bus.round_reset !== 1'b0 || bus.score1 !== 3'd1) begin errors++; $display("FAIL win1_after leds=%b win1=%b rr=%b score1=%0d exp %b/0/0/1", bus.leds, bus.win1, bus.round_reset, bus.score1, LED_C); end
    endtask

    task automatic test_score_saturation();
        logic [2:0] exp_s2;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 5; i++) tick(CMD_L);
            for (int i = 0; i < 5; i++) tick(CMD_HOLD);
            exp_s2 = (r < 7) ? 3'(r + 1) : 3'd7;
            checks++; if (bus.score2 !== exp_s2 || bus.score1 !== 3'd0 || bus.leds !== LED_C) begin errors++; $display("FAIL sat_round%0d score2=%0d score1=%0d leds=%b exp %0d/0/%b", r, bus.score2, bus.score1, bus.leds, exp_s2, LED_C); end
        end
    endtask

    task automatic test_won_ignores_cmd();
        for (int i = 0; i < 5; i++) tick(CMD_L);
        checks++; if (bus.win2 !== 1'b1 || bus.leds !== LED_P2 || bus.score2 !== 3'd7) begin errors++; $display("FAIL ign_win win2=%b leds=%b score2=%0d exp 1/%b/7", bus.win2, bus.leds, bus.score2, LED_P2); end
        for (int i = 1; i <= 3; i++) begin
            tick((i % 2 == 1) ? CMD_R : CMD_L);
            checks++; if (bus.leds !== LED_P2 || bus.round_reset !== 1'b0 || bus.win2 !== 1'b1) begin errors++; $display("FAIL ign_won%0d leds=%b rr=%b win2=%b exp %b/0/1", i, bus.leds, bus.round_reset, bus.win2, LED_P2); end
        end
        tick(CMD_L);
        checks++; if (bus.round_reset !== 1'b1 || bus.leds !== LED_P2) begin errors++; $display("FAIL ign_rr rr=%b leds=%b exp 1/%b", bus.round_reset, bus.leds, LED_P2); end
        tick(CMD_R);
        checks++; if (bus.leds !== LED_C || bus.round_reset !== 1'b0 || bus.win2 !== 1'b0) begin errors++; $display("FAIL ign_after leds=%b rr=%b win2=%b exp %b/0/0", bus.leds, bus.round_reset, bus.win2, LED_C); end
    endtask

    task automatic test_reset_in_won();
        for (int i = 0; i < 5; i++) tick(CMD_L);
        tick(CMD_HOLD);
        checks++; if (bus.win2 !== 1'b1) begin errors++; $display("FAIL rwon_pre win2=%b exp=1", bus.win2); end
        reset = 1'b1;
        tick(CMD_HOLD);
        reset = 1'b0;
        checks++; if (bus.leds !== LED_C || bus.win2 !== 1'b0 || bus.round_reset !== 1'b0) begin errors++; $display("FAIL rwon_state leds=%b win2=%b rr=%b exp %b/0/0", bus.leds, bus.win2, bus.round_reset, LED_C); end
        checks++; if ({bus.score1, bus.score2} !== 6'd0) begin errors++; $display("FAIL rwon_scores got=%0d/%0d exp=0/0", bus.score1, bus.score2); end
        for (int i = 0; i < 6; i++) begin
            tick(CMD_HOLD);
            checks++; if (bus.round_reset !== 1'b0 || bus.leds !== LED_C) begin errors++; $display("FAIL rwon_quiet%0d rr=%b leds=%b exp 0/%b", i, bus.round_reset, bus.leds, LED_C); end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ill [3];
        ill[0] = 3'b010;
        ill[1] = 3'b011;
        ill[2] = 3'b101;
        tick(CMD_R);
        tick(CMD_R);
        checks++; if (bus.leds !== 9'b000000100) begin errors++; $display("FAIL ill_setup got=%b exp=000000100", bus.leds); end
        for (int i = 0; i < 3; i++) begin
            tick(ill[i]);
            checks++; if (bus.leds !== 9'b000000100 || bus.deviate1 !== 1'b0) begin errors++; $display("FAIL ill_%b leds=%b dev1=%b exp 000000100/0", ill[i], bus.leds, bus.deviate1); end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.cmd = CMD_HOLD;
        test_reset();
        test_moves();
        test_win1();
        test_score_saturation();
        test_won_ignores_cmd();
        test_reset_in_won();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
